// File: rtl/byte_write_packer_pkg.sv
// Shared lane/byte-enable encodings and helpers for the byte write packer.
package byte_pack_pkg;

    localparam logic       LANE_LO = 1'b0;
    localparam logic       LANE_HI = 1'b1;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_FULL = 2'b11;

    function automatic logic [1:0] lane_mask(input logic lane);
        return (lane == LANE_HI) ? BE_HI : BE_LO;
    endfunction

    // Byte placed in its lane with the other lane zeroed.
    function automatic logic [15:0] lane_place(input logic lane, input logic [7:0] data);
        return (lane == LANE_HI) ? {data, 8'h00} : {8'h00, data};
    endfunction

endpackage

// File: rtl/byte_write_packer_if.sv
// Byte-in / word-out handshake bundle of the byte write packer.
interface byte_write_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_lane;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_byteena;

    modport master (
        output in_valid, in_data, in_lane, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_byteena
    );

    modport slave (
        input  in_valid, in_data, in_lane, in_last, out_ready,
        output in_ready, out_valid, out_data, out_byteena
    );

endinterface

// File: rtl/byte_write_packer_timer.sv
// Saturating idle counter; FLUSH_TIMEOUT of 0 pins it at zero and never expires.
module pack_flush_timer #(
    parameter int FLUSH_TIMEOUT = 8,
    parameter int TIMER_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic enable,
    output logic expired
);

    localparam bit                 TIMER_ON = (FLUSH_TIMEOUT != 0);
    localparam logic [TIMER_W-1:0] LIMIT    = TIMER_ON ? TIMER_W'(FLUSH_TIMEOUT - 1) : '0;

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: clear wins, otherwise count up while running and saturate.
    always_comb begin
        count_d = count_q;
        if (clear || !TIMER_ON) begin
            count_d = '0;
        end else if (run && (count_q != LIMIT)) begin
            count_d = count_q + TIMER_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = TIMER_ON && enable && run && (count_q == LIMIT);

endmodule

// File: rtl/byte_write_packer.sv
// Merges lane-tagged bytes into byte-enabled 16-bit words behind a one-deep output slot.
module byte_write_packer
    import byte_pack_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 8,
    parameter int TIMER_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    byte_write_packer_if.slave  bus
);

    logic [15:0] acc_data_q, acc_data_d;
    logic [1:0]  acc_be_q,   acc_be_d;
    logic        pend_q,     pend_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q,  out_data_d;
    logic [1:0]  out_be_q,    out_be_d;

    logic        slot_free_s;
    logic        in_ready_s;
    logic        accept_s;
    logic        partial_s;
    logic [1:0]  mask_s;
    logic [1:0]  merged_be_s;
    logic [15:0] merged_data_s;
    logic        emit_s;
    logic [15:0] emit_data_s;
    logic [1:0]  emit_be_s;
    logic        timer_run_s;
    logic        timer_clear_s;
    logic        timer_expired_s;

    assign slot_free_s   = !out_valid_q || bus.out_ready;
    assign in_ready_s    = slot_free_s && !reset;
    assign accept_s      = bus.in_valid && in_ready_s;
    assign partial_s     = (acc_be_q != BE_NONE);
    assign mask_s        = lane_mask(bus.in_lane);
    assign merged_be_s   = acc_be_q | mask_s;
    assign merged_data_s = (bus.in_lane == LANE_HI) ? {bus.in_data, acc_data_q[7:0]}
                                                    : {acc_data_q[15:8], bus.in_data};

    assign timer_run_s   = partial_s && !accept_s;
    assign timer_clear_s = accept_s || !partial_s || emit_s;

    pack_flush_timer #(
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT),
        .TIMER_W       (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .run     (timer_run_s),
        .enable  (slot_free_s),
        .expired (timer_expired_s)
    );

    // Accumulator update and emit decision; a pending last-flush closes the word like a collision.
    always_comb begin
        acc_data_d  = acc_data_q;
        acc_be_d    = acc_be_q;
        pend_d      = pend_q;
        emit_s      = 1'b0;
        emit_data_s = 16'h0000;
        emit_be_s   = BE_NONE;
        if (accept_s) begin
            if (pend_q || ((acc_be_q & mask_s) != BE_NONE)) begin
                emit_s      = 1'b1;
                emit_data_s = acc_data_q;
                emit_be_s   = acc_be_q;
                acc_data_d  = lane_place(bus.in_lane, bus.in_data);
                acc_be_d    = mask_s;
                pend_d      = bus.in_last;
            end else if ((merged_be_s == BE_FULL) || bus.in_last) begin
                emit_s      = 1'b1;
                emit_data_s = merged_data_s;
                emit_be_s   = merged_be_s;
                acc_data_d  = 16'h0000;
                acc_be_d    = BE_NONE;
                pend_d      = 1'b0;
            end else begin
                acc_data_d  = merged_data_s;
                acc_be_d    = merged_be_s;
                pend_d      = 1'b0;
            end
        end else if ((pend_q && slot_free_s) || timer_expired_s) begin
            emit_s      = 1'b1;
            emit_data_s = acc_data_q;
            emit_be_s   = acc_be_q;
            acc_data_d  = 16'h0000;
            acc_be_d    = BE_NONE;
            pend_d      = 1'b0;
        end else begin
            acc_data_d  = acc_data_q;
            acc_be_d    = acc_be_q;
        end
    end

    // Output slot: load on emit, drain when taken, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        if (emit_s) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_data_s;
            out_be_d    = emit_be_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_data_q  <= 16'h0000;
            acc_be_q    <= BE_NONE;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_be_q    <= BE_NONE;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_be_q    <= acc_be_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_byteena = out_be_q;

endmodule

// File: doc/byte_write_packer.md
Name: byte_write_packer

Overview:
- Upstream feeder for the 16-bit byte-enabled holding register.
- Accepts a stream of single bytes, each tagged with a target lane (low/high byte), and merges them into 16-bit words with a 2-bit byte-enable mask.
- Emits each word through a one-deep valid/ready output slot; out_data/out_byteena drive the register's D/byteena inputs directly.
- A partial word is flushed on lane collision, on an explicit last flag, or after an idle timeout.

Parameters:
- FLUSH_TIMEOUT, 8: idle cycles before a partial word is flushed; 0 disables the timeout flush.
- TIMER_W, 4: idle-timer width; must satisfy 2^TIMER_W > FLUSH_TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte offered.
- in_ready  output  1  byte accepted this cycle when in_valid && in_ready.
- in_data  input  8  byte value.
- in_lane  input  1  0 = bits [7:0], 1 = bits [15:8].
- in_last  input  1  flush the word containing this byte immediately.
- out_valid  output  1  word available.
- out_ready  input  1  downstream takes the word when out_valid && out_ready.
- out_data  output  16  packed word; lanes not enabled read 0.
- out_byteena  output  2  bit0 = low byte valid, bit1 = high byte valid; never 2'b00 while out_valid.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset. While reset is high at a rising edge:
  - out_valid=0, out_data=16'h0000, out_byteena=2'b00.
  - Accumulator (acc_data, acc_be) cleared, idle timer = 0.
  - in_ready is forced low during the reset cycle. A partial word present when reset asserts is discarded, and no word is emitted.
- Definitions:
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && !reset, a combinational function of slot_free.
  - acc_state: EMPTY (acc_be=00) or PARTIAL (exactly one bit set). FULL is never held; a full merge is emitted in the same cycle.
- On an accepted byte (lane L, lane mask m = 1<<L):
  - Collision (acc_be & m != 0): emit {acc_data, acc_be}. The accumulator is then loaded with the new byte alone; state stays PARTIAL. If in_last is also set, the new byte is not emitted this cycle; it flushes on the next free slot, taking priority over the timeout.
  - No collision: merged_be = acc_be | m, merged_data = acc_data with lane L replaced.
    - If merged_be==2'b11 or in_last: emit the merged word, clear the accumulator, go to EMPTY.
    - Otherwise load the accumulator, go to PARTIAL.
  - The idle timer resets to 0 on every accepted byte.
- Idle timeout:
  - In PARTIAL with no byte accepted, the timer increments each cycle, saturating at FLUSH_TIMEOUT-1.
  - Timer == FLUSH_TIMEOUT-1 and slot_free: emit the accumulator, go to EMPTY, timer = 0.
  - In EMPTY the timer holds 0.
  - An accepted byte in the same cycle as the timeout takes priority; timeout is evaluated only when no byte is accepted.
- Emit: out_data, out_byteena and out_valid=1 are registered, so the output appears 1 cycle after the accept edge. out_valid holds with stable data until out_ready. If out_ready is high and nothing is emitted in that cycle, out_valid drops to 0.
- Back-to-back: with out_ready held high, one word per cycle is sustained (a lo/hi byte pair every 2 cycles yields a word every 2 cycles).
- Pending in_last flush flag (from a collision with in_last): cleared on emit and on reset.

Decomposition:
- Shared package byte_pack_pkg holds:
  - LANE_LO=1'b0, LANE_HI=1'b1.
  - BE_NONE=2'b00, BE_LO=2'b01, BE_HI=2'b10, BE_FULL=2'b11.
  - The lane-to-mask helper function.
- One sub-module, pack_flush_timer: inputs clear, run, enable; parameter FLUSH_TIMEOUT; output expired. It isolates the saturating counter and the disable-on-zero case.

Test Plan:
- Reset, then accept lo=8'hAA, hi=8'h55 on consecutive cycles with out_ready=1 → one word 16'h55AA, byteena 2'b11, out_valid for exactly 1 cycle, 1 cycle after the second accept.
- Accept hi=8'hCC with in_last=1 → out_data=16'hCC00, byteena 2'b10; accumulator EMPTY afterwards.
- Accept lo=8'h11 then lo=8'h22 (collision) → emits 16'h0011/2'b01. After 8 idle cycles, emits 16'h0022/2'b01 by timeout.
- out_ready=0 with a word pending → in_ready=0, out_data stable across 5 cycles. Raise out_ready → word taken, in_ready returns high the same cycle.
- Accept lo=8'h33, assert reset next cycle, release → no word is ever emitted and all outputs are 0. Next pair lo=8'h01, hi=8'h02 → 16'h0201/2'b11.
- FLUSH_TIMEOUT=0 build: accept a single lo byte, idle 100 cycles → no output until a hi byte completes the word.
